image_stream_tx: RTL and testbench

//  Frame-buffer transmitter feeding the smoothing filter's serial pixel input.
//  A host loads an N x N image through a random-access write port. On start,
//  the block streams the image in raster order, row 0 col 0 first, one pixel
//  per accepted beat, with valid/ready handshake and line/frame markers.
//  It sits upstream of the smoothing stage and drives its 'in' port.

---
 rtl/dip_pkg.sv | 19 +
 rtl/dip_frame_ram.sv | 36 +++
 rtl/image_stream_tx.sv | 222 ++++++++++++++++++++++
 tb/tb_image_stream_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dip_pkg.sv
// Shared defaults, FSM encoding and frame-address width helper for the
// image transmit / smoothing pipeline.
package dip_pkg;

    localparam int DIP_N = 128;
    localparam int DIP_M = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } dip_state_e;

    function automatic int dip_addr_w(input int n);
        return 2 * $clog2(n);
    endfunction

endpackage

// File: rtl/dip_frame_ram.sv
// Simple dual-port frame RAM: one write port, one synchronous read port
// with 1-cycle latency. Contents are never reset.
module dip_frame_ram #(
    parameter int W  = 9,
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0] mem_q [0:DEPTH-1];
    logic [W-1:0] rdata_q;

    // write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // read port, data valid the cycle after re_i
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/image_stream_tx.sv
// Frame-buffer transmitter: host loads an N x N image, then the frame is
// streamed in raster order over a valid/ready link with line/frame markers.
module image_stream_tx
    import dip_pkg::*;
#(
    parameter int  N      = DIP_N,
    parameter int  M      = DIP_M,
    localparam int ADDR_W = dip_addr_w(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [M:0]        wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [M:0]        pix_out,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              sol,
    output logic              eol,
    output logic              sof,
    output logic              eof
);
    localparam int            LW   = ADDR_W / 2;
    localparam logic [LW-1:0] LAST = LW'(N - 1);

    // {sol, eol, sof, eof} for a pixel at (r, c)
    function automatic logic [3:0] calc_markers(input logic [LW-1:0] r, input logic [LW-1:0] c);
        logic [3:0] m;
        m[3] = (c == {LW{1'b0}});
        m[2] = (c == LAST);
        m[1] = (r == {LW{1'b0}}) && (c == {LW{1'b0}});
        m[0] = (r == LAST) && (c == LAST);
        return m;
    endfunction

    dip_state_e    state_q, state_d;
    logic [LW-1:0] rd_row_q, rd_row_d, rd_col_q, rd_col_d;
    logic          rd_all_q, rd_all_d;
    logic          pend_q, pend_d;
    logic [LW-1:0] pend_row_q, pend_row_d, pend_col_q, pend_col_d;
    logic          skid_v_q, skid_v_d;
    logic [M:0]    skid_pix_q, skid_pix_d;
    logic [LW-1:0] skid_row_q, skid_row_d, skid_col_q, skid_col_d;
    logic          out_v_q, out_v_d;
    logic [M:0]    out_pix_q, out_pix_d;
    logic [3:0]    mark_q, mark_d;
    logic          busy_q, busy_d, done_q, done_d;

    logic [M:0]    ram_rdata;
    logic          rd_en, ram_we, pop, load_out, has_room;
    logic [1:0]    occ;

    // Write port is only open while idle; a start in the same cycle reads a cycle later.
    assign ram_we = wr_en && (state_q == IDLE);

    dip_frame_ram #(
        .W  (M + 1),
        .AW (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .re_i    (rd_en),
        .raddr_i ({rd_row_q, rd_col_q}),
        .rdata_o (ram_rdata)
    );

    assign pop      = out_v_q && pix_ready;
    assign load_out = !out_v_q || pix_ready;
    assign occ      = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, pend_q};
    // A read may issue only if its data is guaranteed a slot even if the sink stalls.
    assign has_room = (occ - {1'b0, pop}) < 2'd2;

    // Next-state: FSM, read address counter and the output/skid pipe
    always_comb begin
        state_d    = state_q;
        rd_row_d   = rd_row_q;
        rd_col_d   = rd_col_q;
        rd_all_d   = rd_all_q;
        pend_d     = 1'b0;
        pend_row_d = pend_row_q;
        pend_col_d = pend_col_q;
        skid_v_d   = skid_v_q;
        skid_pix_d = skid_pix_q;
        skid_row_d = skid_row_q;
        skid_col_d = skid_col_q;
        out_v_d    = out_v_q;
        out_pix_d  = out_pix_q;
        mark_d     = mark_q;
        rd_en      = 1'b0;

        case (state_q)
            IDLE: begin
                rd_row_d = {LW{1'b0}};
                rd_col_d = {LW{1'b0}};
                rd_all_d = 1'b0;
                if (start) begin
                    state_d = PRIME;
                end else begin
                    state_d = IDLE;
                end
            end
            PRIME:   state_d = STREAM;
            STREAM: begin
                if (pop && mark_q[0]) begin
                    state_d = DONE;
                end else begin
                    state_d = STREAM;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if ((state_q == PRIME || state_q == STREAM) && !rd_all_q && has_room) begin
            rd_en      = 1'b1;
            pend_d     = 1'b1;
            pend_row_d = rd_row_q;
            pend_col_d = rd_col_q;
            if (rd_col_q == LAST) begin
                rd_col_d = {LW{1'b0}};
                if (rd_row_q == LAST) begin
                    rd_all_d = 1'b1;
                end else begin
                    rd_row_d = rd_row_q + {{(LW-1){1'b0}}, 1'b1};
                end
            end else begin
                rd_col_d = rd_col_q + {{(LW-1){1'b0}}, 1'b1};
            end
        end else begin
            rd_en = 1'b0;
        end

        // Skid entry is always older than the in-flight read, so it drains first.
        if (load_out) begin
            if (skid_v_q) begin
                out_v_d   = 1'b1;
                out_pix_d = skid_pix_q;
                mark_d    = calc_markers(skid_row_q, skid_col_q);
                if (pend_q) begin
                    skid_pix_d = ram_rdata;
                    skid_row_d = pend_row_q;
                    skid_col_d = pend_col_q;
                end else begin
                    skid_v_d = 1'b0;
                end
            end else if (pend_q) begin
                out_v_d   = 1'b1;
                out_pix_d = ram_rdata;
                mark_d    = calc_markers(pend_row_q, pend_col_q);
            end else begin
                out_v_d = 1'b0;
                mark_d  = 4'b0000;
            end
        end else begin
            if (pend_q) begin
                skid_v_d   = 1'b1;
                skid_pix_d = ram_rdata;
                skid_row_d = pend_row_q;
                skid_col_d = pend_col_q;
            end else begin
                skid_v_d = skid_v_q;
            end
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_row_q   <= {LW{1'b0}};
            rd_col_q   <= {LW{1'b0}};
            rd_all_q   <= 1'b0;
            pend_q     <= 1'b0;
            pend_row_q <= {LW{1'b0}};
            pend_col_q <= {LW{1'b0}};
            skid_v_q   <= 1'b0;
            skid_pix_q <= {(M+1){1'b0}};
            skid_row_q <= {LW{1'b0}};
            skid_col_q <= {LW{1'b0}};
            out_v_q    <= 1'b0;
            out_pix_q  <= {(M+1){1'b0}};
            mark_q     <= 4'b0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_row_q   <= rd_row_d;
            rd_col_q   <= rd_col_d;
            rd_all_q   <= rd_all_d;
            pend_q     <= pend_d;
            pend_row_q <= pend_row_d;
            pend_col_q <= pend_col_d;
            skid_v_q   <= skid_v_d;
            skid_pix_q <= skid_pix_d;
            skid_row_q <= skid_row_d;
            skid_col_q <= skid_col_d;
            out_v_q    <= out_v_d;
            out_pix_q  <= out_pix_d;
            mark_q     <= mark_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pix_out   = out_pix_q;
    assign pix_valid = out_v_q;
    assign sol       = mark_q[3];
    assign eol       = mark_q[2];
    assign sof       = mark_q[1];
    assign eof       = mark_q[0];

endmodule

// File: tb/tb_image_stream_tx.sv
// Scoreboard bench for image_stream_tx on an 8x8 frame: stimulus pushes
// expected beats, a negedge monitor pops and compares every accepted beat.
module tb_image_stream_tx;
    localparam int N    = 8;
    localparam int M    = 8;
    localparam int AW   = 6;
    localparam int NPIX = N * N;

    typedef struct packed {
        logic [M:0] pix;
        logic       sol;
        logic       eol;
        logic       sof;
        logic       eof;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [M:0]    wr_data = '0;
    logic          start = 1'b0;
    logic          pix_ready = 1'b0;
    logic          busy, done, pix_valid, sol, eol, sof, eof;
    logic [M:0]    pix_out;

    beat_t      sb_q[$];
    logic [M:0] exp_mem [NPIX];
    int checks = 0, errors = 0;
    int beat_cnt = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
    int rdy_mode = 0;

    image_stream_tx #(.N(N), .M(M)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy), .done(done), .pix_out(pix_out),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .sol(sol), .eol(eol), .sof(sof), .eof(eof)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // ready source: 0 = always ready, 1 = pseudo-random, 2 = stalled
    initial forever begin
        @(posedge clk);
        #2;
        case (rdy_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = ($urandom_range(0, 1) == 1);
            default: pix_ready = 1'b0;
        endcase
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int i = 0; i < NPIX; i++) begin
            beat_t b;
            b.pix = exp_mem[i];
            b.sol = ((i % N) == 0);
            b.eol = ((i % N) == N - 1);
            b.sof = (i == 0);
            b.eof = (i == NPIX - 1);
            sb_q.push_back(b);
        end
    endtask

    task automatic start_frame(input bit with_wr, input int a, input int d);
        beat_cnt = 0;
        if (with_wr) begin
            wr_en      = 1'b1;
            wr_addr    = AW'(a);
            wr_data    = (M+1)'(d);
            exp_mem[a] = (M+1)'(d);
        end
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        chk("busy_rise", busy, 1);
        chk("latency_edge1", pix_valid, 0);
        tick();
        chk("latency_edge2", pix_valid, 0);
        tick();
        chk("latency_edge3", pix_valid, 1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles, required done=1", budget);
        end
        chk("sb_empty_at_done", sb_q.size(), 0);
        tick();
        chk("busy_fall", busy, 0);
        chk("done_one_cycle", done, 0);
    endtask

    // monitor: compare accepted beats, stall stability and done timing
    initial begin
        beat_t exp_b, held;
        bit    hold_chk = 0, eof_pend = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_chk = 0;
                eof_pend = 0;
            end else begin
                if (hold_chk) begin
                    chk("stall_valid", pix_valid, 1);
                    chk("stall_hold", {pix_out, sol, eol, sof, eof}, held);
                end
                if (done || eof_pend) begin
                    chk("done_after_eof", done, eof_pend);
                end
                if (eof_pend) begin
                    chk("valid_drop_after_eof", pix_valid, 0);
                end
                eof_pend = 0;
                if (pix_valid && pix_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_beat: got pixel 0x%0h with no beat expected", pix_out);
                    end else begin
                        exp_b = sb_q.pop_front();
                        chk($sformatf("beat%0d", beat_cnt), {pix_out, sol, eol, sof, eof}, exp_b);
                    end
                    if (beat_cnt == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    beat_cnt++;
                    eof_pend = eof;
                end
                hold_chk = pix_valid && !pix_ready;
                held     = {pix_out, sol, eol, sof, eof};
            end
        end
    end

    initial begin
        int n;
        #3;
        chk("rst_valid", pix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pix", pix_out, 0);
        chk("rst_markers", {sol, eol, sof, eof}, 0);
        tick();
        rst = 1'b0;
        tick();

        // ramp load
        for (int i = 0; i < NPIX; i++) begin
            wr_en      = 1'b1;
            wr_addr    = AW'(i);
            wr_data    = (M+1)'(i % 512);
            exp_mem[i] = (M+1)'(i % 512);
            tick();
        end
        wr_en = 1'b0;
        tick();

        // 1: ready held high, gap-free
        rdy_mode = 0;
        tick();
        start_frame(0, 0, 0);
        wait_done(500);
        chk("gapless_t1", last_cyc - first_cyc, NPIX - 1);
        chk("beats_t1", beat_cnt, NPIX);

        // 2: random ready
        rdy_mode = 1;
        start_frame(0, 0, 0);
        wait_done(2000);
        chk("beats_t2", beat_cnt, NPIX);

        // 3: stall 10 cycles on first pixel, then back-to-back
        rdy_mode = 2;
        tick();
        start_frame(0, 0, 0);
        repeat (10) tick();
        chk("stall_first_pix", pix_out, exp_mem[0]);
        chk("stall_first_sof", sof, 1);
        rdy_mode = 0;
        wait_done(500);
        chk("gapless_t3", last_cyc - first_cyc, NPIX - 1);

        // 4: start and write while busy are ignored
        rdy_mode = 1;
        start_frame(0, 0, 0);
        repeat (5) tick();
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = AW'(5);
        wr_data = (M+1)'(12'h1AB);
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        wait_done(2000);
        rdy_mode = 0;
        start_frame(0, 0, 0);
        wait_done(500);

        // 5: reset mid-frame
        rdy_mode = 1;
        start_frame(0, 0, 0);
        n = 0;
        while (beat_cnt < 37 && n < 1000) begin
            tick();
            n++;
        end
        chk("reached_beat37", (beat_cnt >= 37), 1);
        rst = 1'b1;
        #1;
        chk("midrst_valid", pix_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_markers", {sol, eol, sof, eof}, 0);
        sb_q.delete();
        tick();
        tick();
        rst = 1'b0;
        rdy_mode = 0;
        repeat (3) tick();
        chk("no_done_after_rst", done, 0);
        start_frame(0, 0, 0);
        wait_done(500);
        chk("beats_after_rst", beat_cnt, NPIX);

        // 6: back-to-back frame, start on the cycle after done
        start_frame(0, 0, 0);
        wait_done(500);
        chk("beats_b2b", beat_cnt, NPIX);

        // 7: write and start together in idle, new data streams first
        start_frame(1, 0, 'h155);
        wait_done(500);
        chk("beats_wr_start", beat_cnt, NPIX);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
